// File: rtl/data_1_to_4.sv
// data_1_to_4 -- registered 1-to-4 data distributor.
//
// One producer offers a word together with a channel select (or a broadcast
// flag). Each accepted word lands in a one-entry holding slot per destination
// channel. Each slot is presented to its sink with a valid/ready handshake.
// A slot can be drained and refilled in the same cycle, so each channel
// streams at one word per cycle. Each channel also keeps a wrapping count of
// completed output handshakes.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     producer handshake (in_ready is combinational from
//                         out_ready, in_sel and in_bcast, never from in_valid)
//   in_data, in_sel       word and destination channel 0..3
//   in_bcast              deliver the word to all four channels
//   out_valid[k]          channel k slot holds a word
//   out_ready[k]          sink k takes the word this cycle
//   out_data0..3          holding register of each channel
//   cnt0..3               completed output handshakes per channel (wrapping)
module data_1_to_4 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0]       vld_p1;
  logic [WIDTH-1:0] data_p1 [4];
  logic [CNT_W-1:0] cnt_p1  [4];

  logic [3:0] can;
  logic [3:0] wr;
  logic [3:0] drain;
  logic       accept;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // Stage 0: handshake decode. A slot can take a word if it is empty or is
  // being drained this cycle.
  always_comb begin
    can    = ~vld_p1 | out_ready;
    in_ready = in_bcast ? (&can) : can[in_sel];
    accept = in_valid & in_ready;
    wr     = 4'b0000;
    if (accept) begin
      wr = in_bcast ? 4'b1111 : (4'b0001 << in_sel);
    end
    drain  = vld_p1 & out_ready;
  end

  // Stage 1: holding slots and delivery counters. A write in the same cycle
  // as a drain keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_p1[k] <= '0;
        cnt_p1[k]  <= '0;
      end
    end else begin
      vld_p1 <= (vld_p1 & ~drain) | wr;
      for (int k = 0; k < 4; k++) begin
        if (wr[k]) begin
          data_p1[k] <= in_data;
        end
        if (drain[k]) begin
          cnt_p1[k] <= cnt_inc(cnt_p1[k]);
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data0 = data_p1[0];
  assign out_data1 = data_p1[1];
  assign out_data2 = data_p1[2];
  assign out_data3 = data_p1[3];
  assign cnt0      = cnt_p1[0];
  assign cnt1      = cnt_p1[1];
  assign cnt2      = cnt_p1[2];
  assign cnt3      = cnt_p1[3];

endmodule

// File: doc/data_1_to_4.md
# data_1_to_4

Registered 1-to-4 data distributor for the datapath: the inverse of the 4-to-1 select path. One 32-bit producer drives word, 2-bit channel select and optional broadcast. The block steers each accepted word into a one-entry holding register per destination channel and presents it with a valid/ready handshake. Destinations are writeback, HI/LO, CP0 and debug sinks. It also keeps per-channel delivered-word counters for debug.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to distribute
- in_sel  input  2  destination channel 0..3; ignored when in_bcast=1
- in_bcast  input  1  deliver word to all four channels
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: sink k takes the word this cycle
- out_data0..out_data3  output  WIDTH each  holding register of channel k
- cnt0..cnt3  output  CNT_W each  completed output handshakes on channel k

## Operation
- Per channel k there is a one-entry slot: full_k (drives out_valid[k]) and data_k (drives out_data_k).
- Slot k can take a word this cycle (can_k) when full_k=0, or when out_ready[k]=1.
- in_ready is combinational:
  - when in_bcast=1: can_0 & can_1 & can_2 & can_3
  - otherwise: can_[in_sel]
- Accept = in_valid & in_ready.
  - Unicast accept: write data_[in_sel] and set full_[in_sel].
  - Broadcast accept: write all four slots and set all four full bits.
- Drain on channel k = full_k & out_ready[k].
  - full_k clears unless the same cycle writes slot k.
  - Simultaneous drain and write: full_k stays 1 and data_k takes the new word. This gives no bubble and no loss.
- Channels not targeted are unaffected. One channel stalled does not block unicast traffic to the others. Broadcast waits for all four.
- out_data_k is held stable while out_valid[k]=1 and out_ready[k]=0.
- Counters:
  - cnt_k increments by 1 on each drain of channel k.
  - A counter wraps from 2^CNT_W-1 to 0.
  - Counters are not reset by anything except rst_n.
- in_valid=0: no slot is written. in_data, in_sel and in_bcast are don't-care.

## Timing
- Reset (rst_n=0 at a clock edge):
  - out_valid=4'b0000
  - out_data0..3=0
  - cnt0..3=0
  - Pending words are discarded, including words mid-handshake.
  - in_ready during reset is don't-care. The producer must not rely on acceptance while rst_n=0.
- Latency: a word accepted at edge N appears on out_valid/out_data at edge N, visible in cycle N+1. Latency is 1 cycle.
- Throughput:
  - 1 word/cycle per channel when its sink holds out_ready=1.
  - 1 word/cycle overall.
- Combinational paths:
  - out_ready → in_ready.
  - in_sel/in_bcast → in_ready.
  - No path from in_valid to in_ready.
- A producer may deassert in_valid or change in_sel freely. There is no stickiness requirement on the input side.
- A sink may assert out_ready with out_valid=0. This has no effect and does not increment the counter.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with in_valid=0.
  - Required response: out_valid=0, all out_data and cnt = 0 for 5 cycles.
- Unicast latency:
  - Stimulus: out_ready=4'b1111; send 0xDEADBEEF with sel=2 at cycle 1.
  - Required response: out_valid=4'b0100 and out_data2=0xDEADBEEF in cycle 2; cleared in cycle 3; cnt2=1, other counters 0.
- Backpressure and independence:
  - Stimulus: out_ready[1]=0; send 0x11 to ch1, then 0x22 to ch1, then 0x33 to ch3.
  - Required response:
    - 0x22 is refused (in_ready=0).
    - 0x33 is accepted the same cycle it is presented.
    - out_data1 stays 0x11 throughout the stall.
    - Raise out_ready[1]: 0x11 drains and 0x22 is accepted in that same cycle. ch1 shows 0x22 next cycle with no gap.
- Broadcast gating:
  - Stimulus: ch0 full with out_ready[0]=0; present bcast 0xA5A5A5A5.
  - Required response:
    - in_ready=0 and no slot changes.
    - After out_ready[0]=1, the word is accepted and all four out_valid bits set with 0xA5A5A5A5.
- Back-to-back streaming:
  - Stimulus: 300 consecutive words to ch0 with out_ready[0]=1.
  - Required response: in_ready is 1 every cycle, words arrive in order, and cnt0 ends at 300 mod 256 = 44.
- Reset mid-operation:
  - Stimulus: slots 0 and 3 full, cnt3=5; pulse rst_n=0 for 1 cycle.
  - Required response: out_valid=0 and cnt3=0 next cycle; the held words are never delivered.
